ysyx_22050019_axi_arbiter: RTL
==============================

YSYX_22050019_AXI_ARBITER -- requirements
Module: ysyx_22050019_axi_arbiter

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 64: data width of all R and W channels.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32: address width of all AR and AW channels.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports ifu_ar_valid_i, ifu_ar_addr_i (input, 1/ADDR) and ifu_ar_ready_o (output, 1): IFU read-address channel.
REQ-006 SHALL have ports ifu_r_valid_o, ifu_r_resp_o, ifu_r_data_o (output, 1/2/DATA) and ifu_r_ready_i (input, 1): IFU read-data channel.
REQ-007 SHALL have ports lsu_ar_valid_i, lsu_ar_addr_i (input, 1/ADDR) and lsu_ar_ready_o (output, 1): LSU read-address channel.
REQ-008 SHALL have ports lsu_r_valid_o, lsu_r_resp_o, lsu_r_data_o (output, 1/2/DATA) and lsu_r_ready_i (input, 1): LSU read-data channel.
REQ-009 SHALL have ports lsu_aw_valid_i, lsu_aw_addr_i, lsu_w_valid_i, lsu_w_data_i, lsu_w_strb_i, lsu_b_ready_i (input, 1/ADDR/1/DATA/DATA/8/1) and lsu_aw_ready_o, lsu_w_ready_o, lsu_b_valid_o, lsu_b_resp_o (output, 1/1/1/2): LSU write channels.
REQ-010 SHALL have ports s_ar_valid_o, s_ar_addr_o, s_r_ready_o (output, 1/ADDR/1) and s_ar_ready_i, s_r_valid_i, s_r_resp_i, s_r_data_i (input, 1/1/2/DATA): slave read channels.
REQ-011 SHALL have ports s_aw_valid_o, s_aw_addr_o, s_w_valid_o, s_w_data_o, s_w_strb_o, s_b_ready_o (output, 1/ADDR/1/DATA/DATA/8/1) and s_aw_ready_i, s_w_ready_i, s_b_valid_i, s_b_resp_i (input, 1/1/1/2): slave write channels.

Function
REQ-012 SHALL implement read FSM with states R_IDLE, R_IFU, R_LSU; reset state R_IDLE.
REQ-013 In R_IDLE, SHALL drive ifu/lsu_ar_ready_o=0, ifu/lsu_r_valid_o=0, s_ar_valid_o=0, s_r_ready_o=0.
REQ-014 In R_IDLE, one request valid: next state grants that master; both valid: grant the master not in last_grant (round-robin).
REQ-015 last_grant SHALL update on entry to R_IFU/R_LSU; reset value IFU, so first tie goes to LSU.
REQ-016 Grant latency SHALL be exactly one cycle: request sampled in R_IDLE at edge N, forwarded to slave from cycle N+1.
REQ-017 In R_x, SHALL route granted master AR to slave: s_ar_valid_o = x_ar_valid_i AND NOT ar_done; s_ar_addr_o = x_ar_addr_i; x_ar_ready_o = s_ar_ready_i AND NOT ar_done.
REQ-018 ar_done SHALL set on the s_ar handshake and clear on return to R_IDLE; at most one AR forwarded per grant.
REQ-019 In R_x, SHALL route slave R to the granted master: x_r_valid_o=s_r_valid_i, x_r_data_o=s_r_data_i, x_r_resp_o=s_r_resp_i, s_r_ready_o=x_r_ready_i.
REQ-020 Non-granted master SHALL see ar_ready=0, r_valid=0, r_data=0, r_resp=0 at all times.
REQ-021 R_x SHALL return to R_IDLE on the edge where s_r_valid_i AND s_r_ready_o; a pending other request is granted no earlier than the following cycle.
REQ-022 Granted master deasserting ar_valid before handshake SHALL NOT release the grant; grant held until R handshake.
REQ-023 Write channels SHALL pass through combinationally LSU<->slave with zero latency, independent of read FSM state; simultaneous read and write permitted.

Reset
REQ-024 On rst, SHALL set state R_IDLE, ar_done=0, last_grant=IFU; all read-side outputs 0 in the following cycle.
REQ-025 rst mid-transaction SHALL abandon the grant; a late s_r_valid_i is not accepted (s_r_ready_o=0) and not forwarded.
REQ-026 Write pass-through SHALL be unaffected by rst (no state).

Structure
REQ-027 Package ysyx_22050019_axi_pkg SHALL hold read-FSM state encoding, grant encoding (IFU/LSU) and RESP_OKAY=2'b00.
REQ-028 Round-robin pick SHALL be sub-module ysyx_22050019_rr_arb2 (2 requests, last_grant in, one-hot grant out, combinational).

Verification
REQ-029 IFU ar_valid only, addr 0x80000000, slave returns data 0x1122334455667788 -> grant R_IFU at cycle+1, ifu_r_data_o=0x1122334455667788, lsu_r_valid_o stays 0.
REQ-030 IFU and LSU ar_valid same cycle after reset -> LSU served first, then IFU; two back-to-back ties alternate LSU, IFU, LSU, IFU.
REQ-031 LSU write addr 0x80001000, data 0xDEADBEEF, strb 0x0F concurrent with IFU read -> slave sees both, lsu_b_valid_o mirrors s_b_valid_i, IFU data correct.
REQ-032 Slave holds s_r_valid_i with ifu_r_ready_i=0 for 3 cycles -> grant held, s_r_ready_o=0, pending LSU request not granted until IFU handshake +1 cycle.
REQ-033 rst asserted while in R_LSU before R handshake -> R_IDLE next cycle, all read outputs 0, subsequent s_r_valid_i ignored.
REQ-034 Slave keeps s_ar_ready_i=1 and master holds ar_valid after handshake -> exactly one s_ar_valid_o pulse per grant.

Source files
------------

// File: rtl/ysyx_22050019_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050019_axi_pkg
// Description : Shared encodings for the IFU/LSU AXI arbiter (read FSM state,
//               grant owner, response codes).
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22050019_axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_IFU  = 2'd1,
        R_LSU  = 2'd2
    } rd_state_t;

    typedef enum logic [0:0] {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } grant_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage
`default_nettype wire

// File: rtl/ysyx_22050019_axi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050019_axi_arbiter_if
// Description : One AXI port (AR/R/AW/W/B) as seen between a master and slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22050019_axi_arbiter_if #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic                          ar_valid;
    logic [AXI_ADDR_WIDTH-1:0]     ar_addr;
    logic                          ar_ready;
    logic                          r_valid;
    logic [1:0]                    r_resp;
    logic [AXI_DATA_WIDTH-1:0]     r_data;
    logic                          r_ready;
    logic                          aw_valid;
    logic [AXI_ADDR_WIDTH-1:0]     aw_addr;
    logic                          aw_ready;
    logic                          w_valid;
    logic [AXI_DATA_WIDTH-1:0]     w_data;
    logic [AXI_DATA_WIDTH/8-1:0]   w_strb;
    logic                          w_ready;
    logic                          b_valid;
    logic [1:0]                    b_resp;
    logic                          b_ready;

    modport master (
        output ar_valid, ar_addr, r_ready, aw_valid, aw_addr,
               w_valid, w_data, w_strb, b_ready,
        input  ar_ready, r_valid, r_resp, r_data, aw_ready,
               w_ready, b_valid, b_resp
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr,
               w_valid, w_data, w_strb, b_ready,
        output ar_ready, r_valid, r_resp, r_data, aw_ready,
               w_ready, b_valid, b_resp
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050019_axi_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050019_rr_arb2
// Description : Two-way combinational round-robin pick; bit0 = IFU, bit1 = LSU.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050019_rr_arb2
    import ysyx_22050019_axi_pkg::*;
(
    input  wire logic [1:0] i_req,
    input  wire grant_t     i_last_grant,
    output logic      [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            // On a tie the master that did not win last time goes first
            o_gnt = (i_last_grant == GNT_IFU) ? 2'b10 : 2'b01;
        end else begin
            o_gnt = i_req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050019_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050019_axi_arbiter
// Description : Arbitrates IFU/LSU reads onto one AXI slave; LSU writes pass
//               straight through.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050019_axi_arbiter
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    // IFU read
    input  wire logic                        ifu_ar_valid_i,
    input  wire logic [AXI_ADDR_WIDTH-1:0]   ifu_ar_addr_i,
    output logic                             ifu_ar_ready_o,
    output logic                             ifu_r_valid_o,
    output logic [1:0]                       ifu_r_resp_o,
    output logic [AXI_DATA_WIDTH-1:0]        ifu_r_data_o,
    input  wire logic                        ifu_r_ready_i,
    // LSU read
    input  wire logic                        lsu_ar_valid_i,
    input  wire logic [AXI_ADDR_WIDTH-1:0]   lsu_ar_addr_i,
    output logic                             lsu_ar_ready_o,
    output logic                             lsu_r_valid_o,
    output logic [1:0]                       lsu_r_resp_o,
    output logic [AXI_DATA_WIDTH-1:0]        lsu_r_data_o,
    input  wire logic                        lsu_r_ready_i,
    // LSU write
    input  wire logic                        lsu_aw_valid_i,
    input  wire logic [AXI_ADDR_WIDTH-1:0]   lsu_aw_addr_i,
    output logic                             lsu_aw_ready_o,
    input  wire logic                        lsu_w_valid_i,
    input  wire logic [AXI_DATA_WIDTH-1:0]   lsu_w_data_i,
    input  wire logic [AXI_DATA_WIDTH/8-1:0] lsu_w_strb_i,
    output logic                             lsu_w_ready_o,
    output logic                             lsu_b_valid_o,
    output logic [1:0]                       lsu_b_resp_o,
    input  wire logic                        lsu_b_ready_i,
    // Slave read
    output logic                             s_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]        s_ar_addr_o,
    input  wire logic                        s_ar_ready_i,
    input  wire logic                        s_r_valid_i,
    input  wire logic [1:0]                  s_r_resp_i,
    input  wire logic [AXI_DATA_WIDTH-1:0]   s_r_data_i,
    output logic                             s_r_ready_o,
    // Slave write
    output logic                             s_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]        s_aw_addr_o,
    input  wire logic                        s_aw_ready_i,
    output logic                             s_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]        s_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0]      s_w_strb_o,
    input  wire logic                        s_w_ready_i,
    input  wire logic                        s_b_valid_i,
    input  wire logic [1:0]                  s_b_resp_i,
    output logic                             s_b_ready_o
);

    rd_state_t  r_state;
    rd_state_t  w_next;
    logic       r_ar_done;
    grant_t     r_last_grant;
    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_ar_hs;

    assign w_req = {lsu_ar_valid_i, ifu_ar_valid_i};

    ysyx_22050019_rr_arb2 u_rr_arb2 (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_gnt)
    );

    assign w_ar_hs = s_ar_valid_o & s_ar_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= R_IDLE;
            r_ar_done    <= 1'b0;
            r_last_grant <= GNT_IFU;
        end else begin
            r_state <= w_next;
            if (w_next == R_IDLE) begin
                r_ar_done <= 1'b0;
            end else if (w_ar_hs) begin
                r_ar_done <= 1'b1;
            end
            if (r_state == R_IDLE && w_next == R_IFU) begin
                r_last_grant <= GNT_IFU;
            end else if (r_state == R_IDLE && w_next == R_LSU) begin
                r_last_grant <= GNT_LSU;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        s_ar_valid_o   = 1'b0;
        s_ar_addr_o    = '0;
        s_r_ready_o    = 1'b0;
        ifu_ar_ready_o = 1'b0;
        ifu_r_valid_o  = 1'b0;
        ifu_r_resp_o   = RESP_OKAY;
        ifu_r_data_o   = '0;
        lsu_ar_ready_o = 1'b0;
        lsu_r_valid_o  = 1'b0;
        lsu_r_resp_o   = RESP_OKAY;
        lsu_r_data_o   = '0;
        case (r_state)
            R_IDLE: begin
                if (w_gnt[1]) begin
                    w_next = R_LSU;
                end else if (w_gnt[0]) begin
                    w_next = R_IFU;
                end
            end
            R_IFU: begin
                // ar_done blocks a second AR while the master still holds valid
                s_ar_valid_o   = ifu_ar_valid_i & ~r_ar_done;
                s_ar_addr_o    = ifu_ar_addr_i;
                ifu_ar_ready_o = s_ar_ready_i & ~r_ar_done;
                ifu_r_valid_o  = s_r_valid_i;
                ifu_r_resp_o   = s_r_resp_i;
                ifu_r_data_o   = s_r_data_i;
                s_r_ready_o    = ifu_r_ready_i;
                if (s_r_valid_i && ifu_r_ready_i) begin
                    w_next = R_IDLE;
                end
            end
            R_LSU: begin
                s_ar_valid_o   = lsu_ar_valid_i & ~r_ar_done;
                s_ar_addr_o    = lsu_ar_addr_i;
                lsu_ar_ready_o = s_ar_ready_i & ~r_ar_done;
                lsu_r_valid_o  = s_r_valid_i;
                lsu_r_resp_o   = s_r_resp_i;
                lsu_r_data_o   = s_r_data_i;
                s_r_ready_o    = lsu_r_ready_i;
                if (s_r_valid_i && lsu_r_ready_i) begin
                    w_next = R_IDLE;
                end
            end
            default: begin
                w_next = R_IDLE;
            end
        endcase
    end

    // Writes have a single source, so they are pure wiring
    assign s_aw_valid_o   = lsu_aw_valid_i;
    assign s_aw_addr_o    = lsu_aw_addr_i;
    assign lsu_aw_ready_o = s_aw_ready_i;
    assign s_w_valid_o    = lsu_w_valid_i;
    assign s_w_data_o     = lsu_w_data_i;
    assign s_w_strb_o     = lsu_w_strb_i;
    assign lsu_w_ready_o  = s_w_ready_i;
    assign lsu_b_valid_o  = s_b_valid_i;
    assign lsu_b_resp_o   = s_b_resp_i;
    assign s_b_ready_o    = lsu_b_ready_i;

endmodule
`default_nettype wire
